// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the accepted-key outputs.
interface keypad_scanner_if;
  logic [3:0] row;        // keypad rows, active-low, asynchronous to clk
  logic [3:0] col;        // column drives, active-low, one-cold
  logic [3:0] key_code;   // last accepted key
  logic       key_valid;  // one-cycle pulse per accepted press
  logic       key_down;   // accepted key considered held

  // Scanner side: drives columns and key outputs, samples rows.
  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_down
  );

  // Keypad/consumer side.
  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column multiplexing, per-scan classification and
// scan-level debounce producing one key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_BITS      = 17,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             clear,
  keypad_scanner_if.master kp
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned POP_W   = 5;
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Row synchronizer and scan datapath registers
  logic [3:0]           row_meta_q;
  logic [3:0]           row_sync_q;
  logic [SCAN_BITS-1:0] dwell_q;
  logic [1:0]           col_idx_q;
  logic [3:0]           col_q;
  logic [15:0]          acc_q;
  logic                 scan_done_q;

  // Debounce FSM registers
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           cand_q, cand_d;
  logic [3:0]           key_code_q, key_code_d;
  logic                 key_valid_q, key_valid_d;
  logic                 key_down_q, key_down_d;

  // Scan helpers
  logic                 dwell_last;
  logic [1:0]           col_idx_nxt;
  logic [15:0]          low;
  logic [POP_W-1:0]     low_cnt;
  logic [3:0]           low_pos;
  logic                 res_none;
  logic                 res_single;
  logic [3:0]           scan_code;
  logic [CNT_W-1:0]     cnt_inc;

  // Matrix position (col*4 + row) to hex key code.
  function automatic logic [3:0] key_of(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'h0;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'hF;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hE;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Dwell end detection and next column index.
  always_comb begin
    dwell_last  = &dwell_q;
    col_idx_nxt = col_idx_q + 2'd1;
  end

  // Row synchronizer, dwell counter, column drive and scan accumulator.
  always_ff @(posedge clk) begin
    if (clear) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      acc_q       <= 16'hFFFF;
      scan_done_q <= 1'b0;
    end else begin
      row_meta_q  <= kp.row;
      row_sync_q  <= row_meta_q;
      dwell_q     <= dwell_q + SCAN_BITS'(1);
      scan_done_q <= 1'b0;
      if (dwell_last) begin
        acc_q[{col_idx_q, 2'b00} +: 4] <= row_sync_q;
        col_idx_q   <= col_idx_nxt;
        col_q       <= ~(4'b0001 << col_idx_nxt);
        scan_done_q <= (col_idx_q == 2'd3);
      end
    end
  end

  // Classify the completed scan: count pressed positions and locate one.
  always_comb begin
    low     = ~acc_q;
    low_cnt = '0;
    low_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      low_cnt = low_cnt + POP_W'(low[i]);
      if (low[i]) begin
        low_pos = 4'(i);
      end
    end
    res_none   = (low_cnt == POP_W'(0));
    res_single = (low_cnt == POP_W'(1));
    scan_code  = key_of(low_pos);
    cnt_inc    = (cnt_q < DEB_CNT) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Debounce FSM state and output registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  // Debounce FSM next state; advances only on a completed scan.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (scan_done_q) begin
      case (state_q)
        IDLE: begin
          if (res_single) begin
            state_d = PENDING;
            cand_d  = scan_code;
            cnt_d   = CNT_W'(1);
          end
        end
        PENDING: begin
          if (res_single) begin
            if (scan_code == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DEB_CNT) begin
                state_d     = HELD;
                key_code_d  = cand_q;
                key_valid_d = 1'b1;
              end
            end else begin
              cand_d = scan_code;
              cnt_d  = CNT_W'(1);
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (res_none) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (res_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_CNT) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
    key_down_d = (state_d == HELD) || (state_d == RELEASE);
  end

  // Output drive.
  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;

endmodule
